// File: rtl/prio_enc_rr_arb.sv
// prio_enc_rr_arb: registered N-input request arbiter with fixed or round-robin priority.
//   clk, rst : clock; synchronous active-high reset
//   EN, Din  : request enable and request lines; requests latch into sticky pending bits
//   mode     : 0 = fixed priority (highest index wins), 1 = round-robin
//   ready    : consumer accepts Y on an edge where valid & ready
//   Y, valid : granted index and its qualifier; Y is held while valid & !ready
//   pending  : sticky request register
module prio_enc_rr_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] Din,
  input  logic         mode,
  input  logic         ready,
  output logic [W-1:0] Y,
  output logic         valid,
  output logic [N-1:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] sel_vec;
  logic         sel_found;
  logic [W-1:0] sel_idx;

  // Descending search starting one below start_after, wrapping N-1 after 0.
  // Fixed priority is the same search with start_after = 0 (start at N-1).
  function automatic logic [W:0] pick(input logic [N-1:0] req,
                                      input logic         rr,
                                      input logic [W-1:0] start_after);
    int unsigned base;
    int unsigned idx;
    logic        found;
    logic [W-1:0] sel;
    found = 1'b0;
    sel   = '0;
    base  = rr ? 32'(start_after) : 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (base + N - 1 - k) % N;
      if (!found && req[idx[W-1:0]]) begin
        found = 1'b1;
        sel   = idx[W-1:0];
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    accept = (state_q == GRANT) && ready;

    clr = '0;
    if (accept) clr[y_q] = 1'b1;

    // Set wins over clear: a re-request of Y on the accepting edge stays pending.
    pending_d = (pending_q & ~clr) | (EN ? Din : '0);
    ptr_d     = accept ? y_q : ptr_q;

    // Selection looks only at registered pending, with the accepted bit masked,
    // so a back-to-back grant never repeats the index just consumed.
    sel_vec = pending_q & ~clr;
    {sel_found, sel_idx} = pick(sel_vec, mode, ptr_d);

    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          y_d     = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (sel_found) y_d = sel_idx;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      y_q       <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign valid   = (state_q == GRANT);
  assign pending = pending_q;

endmodule

// File: tb/tb_prio_enc_rr_arb.sv
// tb_prio_enc_rr_arb: directed bench for prio_enc_rr_arb (N=8 and N=5 instances).
module tb_prio_enc_rr_arb;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       mode;
  logic       ready;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pend;

  logic       en5;
  logic [4:0] din5;
  logic       mode5;
  logic       ready5;
  logic [2:0] y5;
  logic       valid5;
  logic [4:0] pend5;

  int total;
  int bad;

  prio_enc_rr_arb #(.N(8)) dut (
    .clk(clk), .rst(rst), .EN(en), .Din(din), .mode(mode), .ready(ready),
    .Y(y), .valid(valid), .pending(pend)
  );

  prio_enc_rr_arb #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .EN(en5), .Din(din5), .mode(mode5), .ready(ready5),
    .Y(y5), .valid(valid5), .pending(pend5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; din = '0; mode = 1'b0; ready = 1'b0;
    en5 = 1'b0; din5 = '0; mode5 = 1'b0; ready5 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (valid !== 1'b0 || y !== 3'd0 || pend !== 8'h00) begin
      $display("FAIL reset: valid=%b Y=%0d pending=%h, required valid=0 Y=0 pending=00", valid, y, pend);
      bad++;
    end
    total++;
    if (valid5 !== 1'b0 || y5 !== 3'd0 || pend5 !== 5'h00) begin
      $display("FAIL reset5: valid=%b Y=%0d pending=%h, required 0/0/00", valid5, y5, pend5);
      bad++;
    end
  endtask

  task automatic test_idle_zero();
    do_reset();
    en = 1'b1; din = 8'h00; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (valid !== 1'b0 || pend !== 8'h00) begin
        $display("FAIL idle_zero[%0d]: valid=%b pending=%h, required valid=0 pending=00", i, valid, pend);
        bad++;
      end
    end
  endtask

  task automatic test_fixed_drain();
    logic [2:0] exp_y [3];
    exp_y[0] = 3'd7; exp_y[1] = 3'd5; exp_y[2] = 3'd2;
    do_reset();
    en = 1'b1; mode = 1'b0; ready = 1'b1; din = 8'b1010_0100;
    tick();
    din = 8'h00;
    total++;
    if (pend !== 8'hA4 || valid !== 1'b0) begin
      $display("FAIL fixed_latch: pending=%h valid=%b, required pending=a4 valid=0", pend, valid);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid !== 1'b1 || y !== exp_y[i]) begin
        $display("FAIL fixed_seq[%0d]: valid=%b Y=%0d, required valid=1 Y=%0d", i, valid, y, exp_y[i]);
        bad++;
      end
    end
    tick();
    total++;
    if (valid !== 1'b0 || pend !== 8'h00) begin
      $display("FAIL fixed_done: valid=%b pending=%h, required valid=0 pending=00", valid, pend);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_rr [10];
    logic [2:0] exp_fx [4];
    for (int i = 0; i < 8; i++) exp_rr[i] = 3'(7 - i);
    exp_rr[8] = 3'd7; exp_rr[9] = 3'd6;
    exp_fx[0] = 3'd7; exp_fx[1] = 3'd6; exp_fx[2] = 3'd7; exp_fx[3] = 3'd6;

    do_reset();
    en = 1'b1; mode = 1'b1; ready = 1'b1; din = 8'hFF;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (valid !== 1'b1 || y !== exp_rr[i]) begin
        $display("FAIL rr_seq[%0d]: valid=%b Y=%0d, required valid=1 Y=%0d", i, valid, y, exp_rr[i]);
        bad++;
      end
      total++;
      if (valid === 1'b1 && pend[y] !== 1'b1) begin
        $display("FAIL rr_y_pending[%0d]: pending=%h Y=%0d, required pending[Y]=1", i, pend, y);
        bad++;
      end
    end

    // Fixed priority: the accepted index is masked for the back-to-back pick,
    // but its re-request is kept, so 7 and 6 alternate.
    do_reset();
    en = 1'b1; mode = 1'b0; ready = 1'b1; din = 8'hFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (valid !== 1'b1 || y !== exp_fx[i]) begin
        $display("FAIL fixed_hold[%0d]: valid=%b Y=%0d, required valid=1 Y=%0d", i, valid, y, exp_fx[i]);
        bad++;
      end
    end
    total++;
    if (pend !== 8'hFF) begin
      $display("FAIL fixed_hold_pend: pending=%h, required ff", pend);
      bad++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; mode = 1'b0; ready = 1'b0; din = 8'h09;
    tick();
    din = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) mode = 1'b1;
      tick();
      total++;
      if (valid !== 1'b1 || y !== 3'd3 || pend !== 8'h09) begin
        $display("FAIL stall[%0d]: valid=%b Y=%0d pending=%h, required valid=1 Y=3 pending=09", i, valid, y, pend);
        bad++;
      end
    end
    ready = 1'b1;
    tick();
    total++;
    if (valid !== 1'b1 || y !== 3'd0 || pend !== 8'h01) begin
      $display("FAIL stall_accept: valid=%b Y=%0d pending=%h, required valid=1 Y=0 pending=01", valid, y, pend);
      bad++;
    end
    tick();
    total++;
    if (valid !== 1'b0 || pend !== 8'h00) begin
      $display("FAIL stall_done: valid=%b pending=%h, required valid=0 pending=00", valid, pend);
      bad++;
    end
  endtask

  task automatic test_enable_and_midreset();
    do_reset();
    en = 1'b0; din = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid !== 1'b0 || pend !== 8'h00) begin
        $display("FAIL en_off[%0d]: valid=%b pending=%h, required valid=0 pending=00", i, valid, pend);
        bad++;
      end
    end
    en = 1'b1; din = 8'h30; ready = 1'b0;
    tick();
    din = 8'h00;
    tick();
    total++;
    if (valid !== 1'b1 || y !== 3'd5 || pend !== 8'h30) begin
      $display("FAIL pre_rst: valid=%b Y=%0d pending=%h, required valid=1 Y=5 pending=30", valid, y, pend);
      bad++;
    end
    // EN=0 must keep the outstanding request while blocking new ones.
    en = 1'b0; din = 8'h01;
    tick();
    total++;
    if (pend !== 8'h30 || valid !== 1'b1) begin
      $display("FAIL en_hold: pending=%h valid=%b, required pending=30 valid=1", pend, valid);
      bad++;
    end
    rst = 1'b1; ready = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0; din = 8'h00;
    total++;
    if (valid !== 1'b0 || pend !== 8'h00 || y !== 3'd0) begin
      $display("FAIL mid_rst: valid=%b pending=%h Y=%0d, required valid=0 pending=00 Y=0", valid, pend, y);
      bad++;
    end
  endtask

  task automatic test_rr_wrap_n5();
    logic [2:0] exp_y;
    do_reset();
    en5 = 1'b1; mode5 = 1'b1; ready5 = 1'b1; din5 = 5'b10001;
    tick();
    total++;
    if (pend5 !== 5'b10001 || valid5 !== 1'b0) begin
      $display("FAIL n5_latch: pending=%b valid=%b, required pending=10001 valid=0", pend5, valid5);
      bad++;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_y = (i % 2 == 0) ? 3'd4 : 3'd0;
      total++;
      if (valid5 !== 1'b1 || y5 !== exp_y) begin
        $display("FAIL n5_wrap[%0d]: valid=%b Y=%0d, required valid=1 Y=%0d", i, valid5, y5, exp_y);
        bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle_zero();
    test_fixed_drain();
    test_back_to_back();
    test_stall();
    test_enable_and_midreset();
    test_rr_wrap_n5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
